sdram_sched: RTL and testbench
==============================

Name: sdram_sched

Overview:
- Scheduler in front of the nouveau_sdram core.
- Shares the single SDRAM port between three sources:
  - the 68k access path (AS decode already synchronised into the RAM clock domain),
  - an auxiliary requester (screen prefetch / DMA),
  - periodic auto-refresh.
- Issues one operation at a time to the core and tracks owed refreshes.
- Prevents starvation of the auxiliary port.

Parameters:
- REF_INTERVAL, 780, CLK cycles between refresh ticks (7.8 us at 100 MHz).
- REF_MAX_OWED, 4, maximum postponed refreshes; when reached, refresh becomes top priority.
- AUX_STARVE, 8, consecutive CPU grants with AUX pending before AUX is forced next.

Ports:
- CLK, input, 1, RAM clock (RAMCLK domain).
- RST, input, 1, asynchronous active-low reset.
- CPU_REQ, input, 1, level request from the 68k path; held until CPU_ACK.
- CPU_ACK, output, 1, one-cycle pulse: CPU operation complete.
- AUX_REQ, input, 1, level request from the auxiliary requester; held until AUX_ACK.
- AUX_ACK, output, 1, one-cycle pulse: AUX operation complete.
- MEM_START, output, 1, one-cycle pulse to the core: begin operation.
- MEM_OP, output, 2, operation code, valid with MEM_START and held until done. 00 = none, 01 = CPU, 10 = AUX, 11 = refresh.
- MEM_BUSY, input, 1, core busy; rises at most 2 cycles after MEM_START, falls at completion.
- REF_OWED, output, 3, current owed-refresh count.
- REF_OVF, output, 1, sticky: a refresh tick arrived while owed = REF_MAX_OWED.

Behaviour:
Reset (RST low, asynchronous):
- State IDLE; timer = 0; owed = 0; starve count = 0; REF_OVF = 0.
- All outputs 0 (MEM_OP = 00).
- Reset mid-operation aborts the transaction; no ACK is issued.

Refresh timer:
- Counts 0..REF_INTERVAL-1, then wraps to 0.
- On wrap, owed increments, saturating at REF_MAX_OWED; a wrap while saturated sets REF_OVF.
- Wrap in the same cycle as a refresh completion leaves owed unchanged (+1 and -1 cancel).

Per-port re-arm:
- After an ACK, the same port cannot be granted again until its REQ has been seen low for at least 1 cycle.
- This prevents double service of one 68k cycle.

Priority, evaluated in IDLE only, first match wins:
1. owed == REF_MAX_OWED -> refresh.
2. AUX eligible and starve count == AUX_STARVE -> AUX.
3. CPU eligible -> CPU.
4. AUX eligible -> AUX.
5. owed > 0 -> refresh.

Starve count:
- Increments on each CPU grant while AUX_REQ is high and AUX is eligible.
- Cleared on an AUX grant, or when AUX_REQ is low.

State machine:
- IDLE: on a selection, drive MEM_OP, pulse MEM_START, go to ISSUE.
- ISSUE: wait for MEM_BUSY = 1, then go to BUSY. If MEM_BUSY has not risen within 3 cycles of MEM_START, treat the operation as complete and go to DONE (the core accepted and finished fast).
- BUSY: on MEM_BUSY = 0, go to DONE.
- DONE (1 cycle):
  - pulse the ACK of the served port, or decrement owed for a refresh;
  - MEM_OP returns to 00;
  - go to IDLE.

Latency and ordering:
- Minimum latency from REQ (seen in IDLE) to MEM_START is 1 cycle.
- Back-to-back operations are separated by at least one IDLE cycle.
- Requests arriving during an operation wait; they are not queued beyond the REQ level.

Optional Feature:
- Macro: SDRAM_SCHED_AUX_EN.
- Defined: AUX port behaves as above.
- Undefined:
  - AUX_REQ is ignored and AUX_ACK is tied 0;
  - the starvation logic and counter are removed;
  - priority reduces to: forced refresh, CPU, refresh-when-owed.

Test Plan:
- Idle, no requests, REF_INTERVAL = 16 -> first MEM_START with MEM_OP = 11 at cycle 17 after reset release; REF_OWED returns to 0 after the core busy pulse.
- CPU_REQ held continuously for 5 × REF_INTERVAL, core busy 3 cycles per op, re-arm toggled each ACK -> REF_OWED reaches 4, the next selection is a refresh before CPU, and REF_OVF stays 0.
- Stop servicing (MEM_BUSY held high) for 6 × REF_INTERVAL -> REF_OWED saturates at 4 and REF_OVF = 1 until RST.
- CPU_REQ and AUX_REQ both continuously high and re-armed -> 8 CPU grants, then 1 AUX grant, repeating; with SDRAM_SCHED_AUX_EN undefined, zero AUX_ACK.
- Timer wrap in the same cycle as refresh DONE with owed = 2 -> owed remains 2.
- Assert RST during BUSY of a CPU operation -> no CPU_ACK; all outputs 0 within the same cycle; after release, normal refresh at REF_INTERVAL.

Source files
------------

// File: rtl/sdram_sched_if.sv
// sdram_sched_if -- handshake bundle between the SDRAM scheduler, its two
// requesters and the nouveau_sdram core.
//   CPU_REQ/CPU_ACK   : 68k access path level request / one-cycle done pulse
//   AUX_REQ/AUX_ACK   : auxiliary requester level request / one-cycle done pulse
//   MEM_START/MEM_OP  : operation launch pulse and op code towards the core
//   MEM_BUSY          : core busy indication
//   REF_OWED/REF_OVF  : owed-refresh count and sticky refresh overflow
// slave  : the scheduler side
// master : requesters + core side
interface sdram_sched_if;
  logic       CPU_REQ;
  logic       CPU_ACK;
  logic       AUX_REQ;
  logic       AUX_ACK;
  logic       MEM_START;
  logic [1:0] MEM_OP;
  logic       MEM_BUSY;
  logic [2:0] REF_OWED;
  logic       REF_OVF;

  modport slave (
    input  CPU_REQ, AUX_REQ, MEM_BUSY,
    output CPU_ACK, AUX_ACK, MEM_START, MEM_OP, REF_OWED, REF_OVF
  );

  modport master (
    output CPU_REQ, AUX_REQ, MEM_BUSY,
    input  CPU_ACK, AUX_ACK, MEM_START, MEM_OP, REF_OWED, REF_OVF
  );
endinterface

// File: rtl/sdram_sched.sv
// sdram_sched -- arbitrates the single nouveau_sdram port between the 68k
// path, an auxiliary requester and periodic auto-refresh. One operation is
// in flight at a time; postponed refreshes are counted and forced once the
// owed count saturates.
// Ports:
//   CLK  : RAM clock
//   RST  : asynchronous active-low reset
//   bus  : sdram_sched_if.slave (requests/acks, core start/op/busy, refresh status)
// Build option:
//   SDRAM_SCHED_AUX_EN defined   -> AUX port active with anti-starvation forcing
//   SDRAM_SCHED_AUX_EN undefined -> AUX_REQ ignored, AUX_ACK tied 0
module sdram_sched #(
  parameter int unsigned REF_INTERVAL = 780,
  parameter int unsigned REF_MAX_OWED = 4,
  parameter int unsigned AUX_STARVE   = 8
) (
  input logic          CLK,
  input logic          RST,
  sdram_sched_if.slave bus
);

  localparam int unsigned TW       = $clog2(REF_INTERVAL);
  localparam logic [2:0]  OWED_MAX = 3'(REF_MAX_OWED);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_CPU  = 2'b01;
  localparam logic [1:0] OP_AUX  = 2'b10;
  localparam logic [1:0] OP_REF  = 2'b11;

  logic [1:0]    state;
  logic [1:0]    cur_op;
  logic [1:0]    mem_op;
  logic [1:0]    wait_cnt;
  logic [1:0]    sel;
  logic          mem_start;
  logic [TW-1:0] timer;
  logic [2:0]    owed;
  logic          ovf;
  logic          cpu_armed;
  logic          cpu_elig;
  logic          tick;
  logic          ref_done;
  logic          enter_done;

  assign cpu_elig   = bus.CPU_REQ & cpu_armed;
  assign tick       = (timer == TW'(REF_INTERVAL - 1));
  assign ref_done   = (state == S_DONE) && (cur_op == OP_REF);
  // ISSUE gives up after its third cycle without MEM_BUSY: the core finished
  // before busy could be observed.
  assign enter_done = ((state == S_ISSUE) && !bus.MEM_BUSY && (wait_cnt == 2'd2)) ||
                      ((state == S_BUSY)  && !bus.MEM_BUSY);

`ifdef SDRAM_SCHED_AUX_EN
  localparam int unsigned SW = $clog2(AUX_STARVE + 1);

  logic          aux_armed;
  logic          aux_elig;
  logic [SW-1:0] starve;

  assign aux_elig    = bus.AUX_REQ & aux_armed;
  assign bus.AUX_ACK = (state == S_DONE) && (cur_op == OP_AUX);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      aux_armed <= 1'b1;
    end else if (enter_done && (cur_op == OP_AUX)) begin
      aux_armed <= 1'b0;
    end else if (!bus.AUX_REQ) begin
      aux_armed <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      starve <= '0;
    end else if (!bus.AUX_REQ) begin
      starve <= '0;
    end else if ((state == S_IDLE) && (sel == OP_AUX)) begin
      starve <= '0;
    end else if ((state == S_IDLE) && (sel == OP_CPU) && aux_elig &&
                 (starve != SW'(AUX_STARVE))) begin
      starve <= starve + 1'b1;
    end
  end
`else
  logic        unused_aux_req;
  logic [31:0] unused_aux_starve;
  assign unused_aux_req    = bus.AUX_REQ;
  assign unused_aux_starve = AUX_STARVE;
  assign bus.AUX_ACK       = 1'b0;
`endif

  always_comb begin
    sel = OP_NONE;
    if (owed == OWED_MAX) begin
      sel = OP_REF;
`ifdef SDRAM_SCHED_AUX_EN
    end else if (aux_elig && (starve == SW'(AUX_STARVE))) begin
      sel = OP_AUX;
`endif
    end else if (cpu_elig) begin
      sel = OP_CPU;
`ifdef SDRAM_SCHED_AUX_EN
    end else if (aux_elig) begin
      sel = OP_AUX;
`endif
    end else if (owed != 3'd0) begin
      sel = OP_REF;
    end
  end

  // cur_op survives into DONE (for the ack / owed decrement) while the
  // MEM_OP register is already cleared on DONE entry.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      cur_op    <= OP_NONE;
      mem_op    <= OP_NONE;
      mem_start <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      mem_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel != OP_NONE) begin
            state     <= S_ISSUE;
            cur_op    <= sel;
            mem_op    <= sel;
            mem_start <= 1'b1;
            wait_cnt  <= '0;
          end
        end
        S_ISSUE: begin
          if (bus.MEM_BUSY) begin
            state <= S_BUSY;
          end else if (wait_cnt == 2'd2) begin
            state  <= S_DONE;
            mem_op <= OP_NONE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_BUSY: begin
          if (!bus.MEM_BUSY) begin
            state  <= S_DONE;
            mem_op <= OP_NONE;
          end
        end
        default: begin
          state  <= S_IDLE;
          cur_op <= OP_NONE;
        end
      endcase
    end
  end

  // Disarm on DONE entry rather than exit so that a REQ dropped during the
  // ack cycle already counts as the re-arm low cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cpu_armed <= 1'b1;
    end else if (enter_done && (cur_op == OP_CPU)) begin
      cpu_armed <= 1'b0;
    end else if (!bus.CPU_REQ) begin
      cpu_armed <= 1'b1;
    end
  end

  // A wrap coinciding with a refresh completion cancels out.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      timer <= '0;
      owed  <= '0;
      ovf   <= 1'b0;
    end else begin
      timer <= tick ? '0 : timer + 1'b1;
      if (tick && !ref_done) begin
        if (owed == OWED_MAX) begin
          ovf <= 1'b1;
        end else begin
          owed <= owed + 3'd1;
        end
      end else if (ref_done && !tick) begin
        owed <= owed - 3'd1;
      end
    end
  end

  assign bus.CPU_ACK   = (state == S_DONE) && (cur_op == OP_CPU);
  assign bus.MEM_START = mem_start;
  assign bus.MEM_OP    = mem_op;
  assign bus.REF_OWED  = owed;
  assign bus.REF_OVF   = ovf;

endmodule

// File: tb/tb_sdram_sched.sv
module tb_sdram_sched;

  localparam int RI   = 16;
  localparam int MAXO = 4;
  localparam int STV  = 8;
`ifdef SDRAM_SCHED_AUX_EN
  localparam bit AUX_EN = 1'b1;
`else
  localparam bit AUX_EN = 1'b0;
`endif

  localparam int P_DIR   = 0;
  localparam int P_HOG   = 1;
  localparam int P_RND   = 2;
  localparam int P_STALL = 3;
  localparam int P_RST   = 4;

  logic CLK = 1'b0;
  logic RST;

  sdram_sched_if bus ();

  sdram_sched #(
    .REF_INTERVAL(RI),
    .REF_MAX_OWED(MAXO),
    .AUX_STARVE  (STV)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: k = clock edges since reset release; mode 0 idle,
  // 1 operation in flight, 2 completion cycle; op codes 1 CPU, 2 AUX, 3 refresh.
  int k, m_mode, m_left, m_cur, m_owed, m_rel, m_starve;
  bit m_ovf, m_cpu_armed, m_aux_armed;
  // core behaviour for the current operation: busy from cycle p_d for p_L
  // cycles after MEM_START, or never (p_to)
  int p_d, p_L;
  bit p_to, stall_used;
  // requesters: phase 0 low, 1 waiting for ack, 2 lingering high after ack
  int phase, pct, linger;
  bit req[2];
  int ph[2], ctr[2];
  int first, fop, maxo;
  bit hit;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
  endtask

  function automatic logic [8:0] dut_vec();
    return {bus.MEM_START, bus.MEM_OP, bus.CPU_ACK, bus.AUX_ACK, bus.REF_OWED, bus.REF_OVF};
  endfunction

  function automatic logic [8:0] exp_vec();
    logic [1:0] op;
    op = (m_mode == 1) ? 2'(m_cur) : 2'b00;
    return {(m_mode == 1 && m_rel == 0), op, (m_mode == 2 && m_cur == 1),
            (m_mode == 2 && m_cur == 2), 3'(m_owed), m_ovf};
  endfunction

  task automatic reset_model();
    k = 0; m_mode = 0; m_left = 0; m_cur = 0; m_owed = 0; m_rel = 0; m_starve = 0;
    m_ovf = 1'b0; m_cpu_armed = 1'b1; m_aux_armed = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; ph[i] = 0; ctr[i] = 0;
    end
  endtask

  task automatic choose_profile();
    p_to = 1'b0;
    case (phase)
      P_DIR: begin p_d = 1; p_L = 2; end
      P_HOG: begin p_d = 0; p_L = 3; end
      P_RST: begin p_d = 0; p_L = 4; end
      default: begin
        if (phase == P_STALL && !stall_used) begin
          p_d = 0; p_L = 6 * RI; stall_used = 1'b1;
        end else begin
          p_to = ($urandom_range(0, 9) == 0);
          p_d  = int'($urandom_range(0, 2));
          p_L  = int'($urandom_range(1, 4));
        end
      end
    endcase
  endtask

  // Drives inputs for the coming edge, then advances the model across it.
  task automatic drive_and_step();
    int sel;
    bit ce, ae, tick, dec, fin, ackv;
    for (int i = 0; i < 2; i++) begin
      ackv = (i == 0) ? bus.CPU_ACK : bus.AUX_ACK;
      case (ph[i])
        0: begin
          req[i] = 1'b0;
          if (int'($urandom_range(0, 99)) < pct) begin req[i] = 1'b1; ph[i] = 1; end
        end
        1: if (ackv) begin
          ctr[i] = int'($urandom_range(0, linger));
          if (ctr[i] == 0) begin req[i] = 1'b0; ph[i] = 0; end
          else ph[i] = 2;
        end
        default: begin
          ctr[i]--;
          if (ctr[i] == 0) begin req[i] = 1'b0; ph[i] = 0; end
        end
      endcase
    end
    if (!AUX_EN) req[1] = 1'($urandom_range(0, 1));
    bus.CPU_REQ  = req[0];
    bus.AUX_REQ  = req[1];
    bus.MEM_BUSY = (m_mode == 1) && !p_to && (m_rel >= p_d) && (m_rel < p_d + p_L);

    tick = ((k + 1) % RI) == 0;
    dec  = (m_mode == 2) && (m_cur == 3);
    fin  = (m_mode == 1) && (m_left == 1);
    ce   = req[0] && m_cpu_armed;
    ae   = AUX_EN && req[1] && m_aux_armed;

    sel = 0;
    if (m_mode == 0) begin
      if (m_owed == MAXO)              sel = 3;
      else if (ae && m_starve == STV)  sel = 2;
      else if (ce)                     sel = 1;
      else if (ae)                     sel = 2;
      else if (m_owed > 0)             sel = 3;
    end

    if (AUX_EN) begin
      if (!req[1])              m_starve = 0;
      else if (sel == 2)        m_starve = 0;
      else if (sel == 1 && ae)  m_starve++;
    end

    if (fin && m_cur == 1) m_cpu_armed = 1'b0;
    else if (!req[0])      m_cpu_armed = 1'b1;
    if (fin && m_cur == 2) m_aux_armed = 1'b0;
    else if (!req[1])      m_aux_armed = 1'b1;

    if (tick && !dec) begin
      if (m_owed == MAXO) m_ovf = 1'b1;
      else m_owed++;
    end else if (dec && !tick) begin
      m_owed--;
    end

    case (m_mode)
      0: if (sel != 0) begin
        m_mode = 1; m_cur = sel; m_rel = 0;
        choose_profile();
        m_left = p_to ? 3 : p_d + p_L + 1;
      end
      1: begin
        m_rel++; m_left--;
        if (m_left == 0) m_mode = 2;
      end
      default: begin m_mode = 0; m_cur = 0; end
    endcase
    k++;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check_eq(tag, 32'(dut_vec()), 32'(exp_vec()));
      if (int'(bus.REF_OWED) > maxo) maxo = int'(bus.REF_OWED);
      if (bus.MEM_START && first < 0) begin first = k; fop = int'(bus.MEM_OP); end
      drive_and_step();
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b0;
    bus.CPU_REQ = 1'b0; bus.AUX_REQ = 1'b0; bus.MEM_BUSY = 1'b0;
    reset_model();
    phase = P_DIR; pct = 0; linger = 0; stall_used = 1'b0;
    p_d = 0; p_L = 1; p_to = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("reset_state", 32'(dut_vec()), 32'd0);

    // idle: first refresh launched at cycle 17, owed back to 0 afterwards
    RST = 1'b1; first = -1;
    drive_and_step();
    run("idle", 30);
    check_eq("first_start_cycle", 32'(first), 32'd17);
    check_eq("first_op_refresh", 32'(fop), 32'd3);
    check_eq("owed_after_ref", 32'(bus.REF_OWED), 32'd0);

    // CPU hog: owed climbs to the limit, forced refreshes prevent overflow
    phase = P_HOG; pct = 100; linger = 0; maxo = 0;
    run("hog", 6 * RI);
    check_eq("hog_max_owed", 32'(maxo), 32'd4);
    check_eq("hog_ovf", 32'(bus.REF_OVF), 32'd0);

    phase = P_RND; pct = 40; linger = 2;
    run("rand", 1500);

    // core stalls for 6 refresh intervals: owed saturates, overflow sticks
    phase = P_STALL; pct = 0; stall_used = 1'b0; hit = 1'b0;
    for (int i = 0; i < 10 * RI && !hit; i++) begin
      @(negedge CLK);
      check_eq("stall", 32'(dut_vec()), 32'(exp_vec()));
      if (m_mode == 1 && p_L == 6 * RI && m_rel == 6 * RI - 1) hit = 1'b1;
      else drive_and_step();
    end
    check_eq("stall_reached", 32'(hit), 32'd1);
    check_eq("stall_owed", 32'(bus.REF_OWED), 32'd4);
    check_eq("stall_ovf", 32'(bus.REF_OVF), 32'd1);
    drive_and_step();
    phase = P_RND; pct = 50; linger = 2;
    run("post_stall", 300);

    // reset during BUSY of a CPU operation
    phase = P_RST; pct = 100; linger = 0; hit = 1'b0;
    for (int i = 0; i < 20 * RI && !hit; i++) begin
      @(negedge CLK);
      check_eq("pre_rst", 32'(dut_vec()), 32'(exp_vec()));
      if (m_mode == 1 && m_cur == 1 && !p_to && p_d == 0 && p_L >= 3 && m_rel == 2) hit = 1'b1;
      else drive_and_step();
    end
    check_eq("rst_in_busy_reached", 32'(hit), 32'd1);
    RST = 1'b0;
    #1;
    check_eq("rst_async_outputs", 32'(dut_vec()), 32'd0);
    reset_model();
    bus.CPU_REQ = 1'b0; bus.AUX_REQ = 1'b0; bus.MEM_BUSY = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check_eq("rst_held", 32'(dut_vec()), 32'd0);
    end
    RST = 1'b1; phase = P_DIR; pct = 0; first = -1;
    drive_and_step();
    run("post_rst", 40);
    check_eq("post_rst_first_start", 32'(first), 32'd17);
    check_eq("post_rst_ovf", 32'(bus.REF_OVF), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
